// File: rtl/scroll_window_reader_pkg.sv
// Shared definitions for the scroll path: FSM state encodings, the default
// blank character code and a constant-evaluable ceiling-log2 helper.
package scroll_window_reader_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  // Code shown on every digit while no message is loaded.
  localparam logic [4:0] BLANK_DEFAULT = 5'h1F;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/scroll_window_reader_prescaler.sv
// Free-running divide-by-TICK_DIV counter for the scroll blocks.
// Counts while en is high, emits a one-cycle tick on the terminal count and
// wraps to zero; clr forces the count to zero and suppresses the tick.
module scroll_prescaler
  import scroll_window_reader_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNTW = clog2(TICK_DIV);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == CNTW'(TICK_DIV - 1));

  // Next count: clear wins, otherwise advance and wrap on the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNTW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scroll_window_reader.sv
// Scroll window reader: captures a message as a stream of character codes,
// then shows a WIN-digit window onto it that rotates one character every
// TICK_DIV clocks, wrapping circularly over the loaded length.
module scroll_window_reader
  import scroll_window_reader_pkg::*;
#(
  parameter int            CW       = 5,
  parameter int            MSG_LEN  = 16,
  parameter int            WIN      = 4,
  parameter int            TICK_DIV = 25000000,
  parameter logic [CW-1:0] BLANK    = CW'(BLANK_DEFAULT)
) (
  input  logic              in_CLK,
  input  logic              in_RST,
  input  logic              in_WR_EN,
  input  logic [CW-1:0]     in_WR_DATA,
  input  logic              in_WR_LAST,
  output logic              out_WR_READY,
  input  logic              in_PAUSE,
  input  logic              in_CLEAR,
  output logic [WIN*CW-1:0] out_WIN,
  output logic              out_STEP,
  output logic              out_ACTIVE
);

  localparam int LW = clog2(MSG_LEN + 1);
  localparam int PW = (clog2(MSG_LEN) < 1) ? 1 : clog2(MSG_LEN);
  // Wide enough for ptr + k before wrapping.
  localparam int IW = clog2(MSG_LEN + WIN);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          step_q, step_d;
  logic [CW-1:0] msg_q [MSG_LEN];
  logic [CW-1:0] msg_d [MSG_LEN];

  logic          pre_en;
  logic          pre_clr;
  logic          tick;

  assign out_WR_READY = (state_q == S_EMPTY) || (state_q == S_LOAD);
  assign out_ACTIVE   = (state_q == S_RUN)   || (state_q == S_HOLD);
  assign out_STEP     = step_q;

  // The pause level gates the prescaler directly, so the count freezes in
  // the cycle pause rises and resumes in the cycle it falls.
  assign pre_en = out_ACTIVE && !in_PAUSE && !in_CLEAR;

  scroll_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (in_CLK),
    .rst  (in_RST),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  // FSM next state, message length, scroll pointer and buffer writes.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    step_d  = tick;
    pre_clr = 1'b0;
    msg_d   = msg_q;
    if (in_CLEAR) begin
      // Buffer contents are kept; the window blanks because of the state.
      state_d = S_EMPTY;
      len_d   = '0;
      ptr_d   = '0;
      pre_clr = 1'b1;
    end else begin
      case (state_q)
        S_EMPTY, S_LOAD: begin
          // len is 0 in EMPTY, so the same path writes slot 0 there.
          if (in_WR_EN) begin
            msg_d[len_q[PW-1:0]] = in_WR_DATA;
            len_d = len_q + LW'(1);
            if (in_WR_LAST || (len_d == LW'(MSG_LEN))) begin
              state_d = S_RUN;
              ptr_d   = '0;
              pre_clr = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_RUN, S_HOLD: begin
          state_d = in_PAUSE ? S_HOLD : S_RUN;
          if (tick) begin
            if ((LW'(ptr_q) + LW'(1)) == len_q) ptr_d = '0;
            else                                ptr_d = ptr_q + PW'(1);
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state_q <= S_EMPTY;
      len_q   <= '0;
      ptr_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
    end
  end

  // Message buffer; every slot returns to BLANK on reset.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= BLANK;
    end else begin
      msg_q <= msg_d;
    end
  end

  // One window digit per generate slice: (ptr + k) mod len by repeated
  // compare-and-subtract, which also covers messages shorter than WIN.
  for (genvar gi = 0; gi < WIN; gi++) begin : g_digit
    logic [IW-1:0] idx;

    // Reduce ptr + k into the loaded length.
    always_comb begin
      idx = IW'(ptr_q) + IW'(gi);
      for (int i = 0; i < WIN; i++) begin
        if (idx >= IW'(len_q)) idx = idx - IW'(len_q);
      end
    end

    assign out_WIN[gi*CW +: CW] = out_ACTIVE ? msg_q[idx[PW-1:0]] : BLANK;
  end

endmodule
